// File: rtl/matrix_key_scanner.sv
// matrix_key_scanner: row-scanned key matrix with per-key debounce and an
// event queue of key press/release reports.
// Optional feature macro KEY_EVENT_QUEUE_EN: when defined the event queue is a
// 4-entry FIFO, otherwise it is a single holding register.
module matrix_key_scanner #(
   parameter int ROWS     = 4,
   parameter int COLS     = 6,
   parameter int DIV      = 16,
   parameter int DEBOUNCE = 4,
   localparam int N       = ROWS * COLS,
   localparam int CW      = (N > 1) ? $clog2(N) : 1
) (
   input  logic            Clk,
   input  logic            Reset,
   output logic [ROWS-1:0] keyrow,
   input  logic [COLS-1:0] keycol,
   output logic [N-1:0]    button,
   output logic            event_valid,
   input  logic            event_ready,
   output logic [CW-1:0]   event_code,
   output logic            event_press,
   output logic            overflow,
   input  logic            overflow_clr
);

   localparam int RW = $clog2(ROWS);
   localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;
`ifdef KEY_EVENT_QUEUE_EN
   localparam int QD = 4;
`else
   localparam int QD = 1;
`endif
   localparam int PW = (QD > 1) ? $clog2(QD) : 1;

   localparam logic [1:0] ST_SETTLE  = 2'd0;
   localparam logic [1:0] ST_EVAL    = 2'd1;
   localparam logic [1:0] ST_ADVANCE = 2'd2;

   logic [1:0]      state_r;
   logic [15:0]     div_r;
   logic [RW-1:0]   row_r;
   logic [KW-1:0]   col_r;
   logic [ROWS-1:0] keyrow_r;
   logic [COLS-1:0] sample_r;
   logic [N-1:0]    button_r;
   logic [3:0]      cnt_r [N];
   logic [CW-1:0]   q_code_r [QD];
   logic            q_press_r [QD];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [2:0]      count_r;
   logic            overflow_r;

   logic [CW-1:0]   key_s;
   logic            sample_bit_s;
   logic            cur_s;
   logic [3:0]      cnt_inc_s;
   logic            differ_s;
   logic            flip_s;
   logic            pop_s;
   logic            full_s;
   logic            drop_s;
   logic            push_s;

   // Wrapping increment for queue pointers.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      if (p == PW'(QD - 1)) begin
         return '0;
      end else begin
         return p + PW'(1);
      end
   endfunction

   // Key under evaluation, debounce decision and queue push/pop/drop control.
   always_comb begin
      key_s        = CW'(int'(row_r) * COLS + int'(col_r));
      sample_bit_s = sample_r[col_r];
      cur_s        = button_r[key_s];
      cnt_inc_s    = cnt_r[key_s] + 4'd1;
      differ_s     = (state_r == ST_EVAL) && (sample_bit_s != cur_s);
      flip_s       = differ_s && (cnt_inc_s == 4'(DEBOUNCE));
      pop_s        = (count_r != 3'd0) && event_ready;
      full_s       = (count_r == 3'(QD));
      drop_s       = flip_s && full_s && !pop_s;
      push_s       = flip_s && !drop_s;
   end

   // Scan sequencer: settle the driven row, latch columns, walk the columns, advance row.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r  <= ST_SETTLE;
         div_r    <= 16'd0;
         row_r    <= '0;
         col_r    <= '0;
         keyrow_r <= ROWS'(1);
         sample_r <= '0;
      end else begin
         case (state_r)
            ST_SETTLE: begin
               if (div_r == 16'(DIV - 1)) begin
                  sample_r <= keycol;
                  col_r    <= '0;
                  div_r    <= 16'd0;
                  state_r  <= ST_EVAL;
               end else begin
                  div_r <= div_r + 16'd1;
               end
            end
            ST_EVAL: begin
               if (col_r == KW'(COLS - 1)) begin
                  state_r <= ST_ADVANCE;
               end else begin
                  col_r <= col_r + KW'(1);
               end
            end
            ST_ADVANCE: begin
               row_r    <= (row_r == RW'(ROWS - 1)) ? '0 : row_r + RW'(1);
               keyrow_r <= {keyrow_r[ROWS-2:0], keyrow_r[ROWS-1]};
               div_r    <= 16'd0;
               state_r  <= ST_SETTLE;
            end
            default: begin
               state_r <= ST_SETTLE;
            end
         endcase
      end
   end

   // Per-key debounce counters and debounced key levels.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         button_r <= '0;
         for (int i = 0; i < N; i++) begin
            cnt_r[i] <= 4'd0;
         end
      end else if (state_r == ST_EVAL) begin
         if (!differ_s) begin
            cnt_r[key_s] <= 4'd0;
         end else if (flip_s) begin
            cnt_r[key_s]    <= 4'd0;
            button_r[key_s] <= ~cur_s;
         end else begin
            cnt_r[key_s] <= cnt_inc_s;
         end
      end
   end

   // Event queue storage, occupancy and sticky overflow flag.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= 3'd0;
         overflow_r <= 1'b0;
         for (int i = 0; i < QD; i++) begin
            q_code_r[i]  <= '0;
            q_press_r[i] <= 1'b0;
         end
      end else begin
         if (push_s) begin
            q_code_r[wr_ptr_r]  <= key_s;
            q_press_r[wr_ptr_r] <= ~cur_s;
            wr_ptr_r            <= ptr_next(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_next(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 3'd1;
            2'b01:   count_r <= count_r - 3'd1;
            default: count_r <= count_r;
         endcase
         if (drop_s) begin
            overflow_r <= 1'b1;
         end else if (overflow_clr) begin
            overflow_r <= 1'b0;
         end
      end
   end

   assign keyrow      = keyrow_r;
   assign button      = button_r;
   assign event_valid = (count_r != 3'd0);
   assign event_code  = q_code_r[rd_ptr_r];
   assign event_press = q_press_r[rd_ptr_r];
   assign overflow    = overflow_r;

endmodule
